// File: rtl/mult_ctrl.sv
// mult_ctrl: issue/writeback controller for a 1..3 cycle pipelined multiplier.
// Each issued op is tracked through three age slots (S1..S3). A writeback
// reservation vector keeps two ops from landing on the single writeback
// port in the same cycle. A register scoreboard on the slots stalls
// RAW/WAW hazards against ops that are not yet retiring.
// Writeback, stage enables and busy are registered. They are computed from
// the next-cycle slot contents, so each one is valid for the cycle the
// slots describe.

module mult_ctrl #(
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [1:0]      req_lat,
    input  logic [RD_W-1:0] req_rd,
    input  logic [RD_W-1:0] req_rs1,
    input  logic [RD_W-1:0] req_rs2,
    input  logic            flush,
    output logic            en_e,
    output logic            en_m,
    output logic            en_w,
    output logic            wb_valid,
    output logic [RD_W-1:0] wb_rd,
    output logic [1:0]      wb_sel,
    output logic            busy
);

    // Effective latency: upper-half ops always take the full three stages,
    // and an encoded latency of zero means three.
    function automatic logic [1:0] eff_latency(input logic [1:0] op, input logic [1:0] lat);
        logic [1:0] l;
        if (op != 2'b00) begin
            l = 2'd3;
        end else if (lat == 2'd0) begin
            l = 2'd3;
        end else begin
            l = lat;
        end
        return l;
    endfunction

    // Slot state; index 0 is S1 (youngest), index 2 is S3 (oldest)
    logic [2:0]      slot_v_r;
    logic [RD_W-1:0] slot_rd_r [3];
    logic [1:0]      slot_l_r  [3];
    logic [2:0]      resv_r;

    // Registered outputs
    logic            wb_valid_r;
    logic [RD_W-1:0] wb_rd_r;
    logic [1:0]      wb_sel_r;
    logic            en_m_r;
    logic            en_w_r;
    logic            busy_r;

    // Combinational decision and next-state terms
    logic [1:0]      lat_s;
    logic [2:0]      retire_s;
    logic            hazard_s;
    logic [2:0]      resv_post_s;
    logic            collide_s;
    logic            ready_s;
    logic            issue_s;
    logic [2:0]      nxt_v_s;
    logic [RD_W-1:0] nxt_rd_s [3];
    logic [1:0]      nxt_l_s  [3];
    logic [2:0]      resv_nxt_s;
    logic            wb_valid_nxt_s;
    logic [RD_W-1:0] wb_rd_nxt_s;
    logic [1:0]      wb_sel_nxt_s;
    logic            en_m_nxt_s;
    logic            en_w_nxt_s;
    logic            busy_nxt_s;

    // Retire detection, hazard/port checks and the issue decision
    always_comb begin
        lat_s    = eff_latency(req_op, req_lat);
        retire_s = 3'b000;
        hazard_s = 1'b0;
        for (int k = 0; k < 3; k++) begin
            retire_s[k] = slot_v_r[k] && (slot_l_r[k] == 2'(k + 1));
            // A retiring op has already delivered its result this cycle, so it
            // cannot block a new request; x0 is never a real dependency.
            if (slot_v_r[k] && !retire_s[k] && (slot_rd_r[k] != '0) &&
                ((req_rs1 == slot_rd_r[k]) || (req_rs2 == slot_rd_r[k]) ||
                 (req_rd == slot_rd_r[k]))) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
        // Bit j of resv_r claims the port j cycles from now; after this
        // cycle's shift, bit L-1 is the cycle a new op of latency L would use.
        resv_post_s = {1'b0, resv_r[2:1]};
        collide_s   = resv_post_s[lat_s - 2'd1];
        ready_s     = !collide_s && !hazard_s;
        issue_s     = req_valid && ready_s && !flush;
    end

    // Slot shift, reservation update and next values of the registered outputs
    always_comb begin
        nxt_v_s    = 3'b000;
        resv_nxt_s = 3'b000;
        for (int k = 0; k < 3; k++) begin
            nxt_rd_s[k] = '0;
            nxt_l_s[k]  = 2'd0;
        end
        if (flush) begin
            nxt_v_s    = 3'b000;
            resv_nxt_s = 3'b000;
        end else begin
            if (issue_s) begin
                nxt_v_s[0]  = 1'b1;
                nxt_rd_s[0] = req_rd;
                nxt_l_s[0]  = lat_s;
                resv_nxt_s  = resv_post_s | (3'b001 << (lat_s - 2'd1));
            end else begin
                resv_nxt_s  = resv_post_s;
            end
            // Ops that did not retire in their current slot age by one slot
            for (int k = 1; k < 3; k++) begin
                if (slot_v_r[k-1] && !retire_s[k-1]) begin
                    nxt_v_s[k]  = 1'b1;
                    nxt_rd_s[k] = slot_rd_r[k-1];
                    nxt_l_s[k]  = slot_l_r[k-1];
                end else begin
                    nxt_v_s[k]  = 1'b0;
                end
            end
        end

        // At most one slot can be in its writeback cycle; the reservation
        // vector guarantees it, the priority order only keeps the mux simple.
        wb_valid_nxt_s = 1'b0;
        wb_rd_nxt_s    = '0;
        wb_sel_nxt_s   = 2'd0;
        if (nxt_v_s[0] && (nxt_l_s[0] == 2'd1)) begin
            wb_valid_nxt_s = 1'b1;
            wb_rd_nxt_s    = nxt_rd_s[0];
            wb_sel_nxt_s   = 2'd0;
        end else if (nxt_v_s[1] && (nxt_l_s[1] == 2'd2)) begin
            wb_valid_nxt_s = 1'b1;
            wb_rd_nxt_s    = nxt_rd_s[1];
            wb_sel_nxt_s   = 2'd1;
        end else if (nxt_v_s[2]) begin
            wb_valid_nxt_s = 1'b1;
            wb_rd_nxt_s    = nxt_rd_s[2];
            wb_sel_nxt_s   = 2'd2;
        end else begin
            wb_valid_nxt_s = 1'b0;
        end

        en_m_nxt_s = nxt_v_s[0] && (nxt_l_s[0] >= 2'd2);
        en_w_nxt_s = nxt_v_s[1] && (nxt_l_s[1] == 2'd3);
        busy_nxt_s = |nxt_v_s;
    end

    // Slot, reservation and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_v_r   <= 3'b000;
            resv_r     <= 3'b000;
            for (int k = 0; k < 3; k++) begin
                slot_rd_r[k] <= '0;
                slot_l_r[k]  <= 2'd0;
            end
            wb_valid_r <= 1'b0;
            wb_rd_r    <= '0;
            wb_sel_r   <= 2'd0;
            en_m_r     <= 1'b0;
            en_w_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            slot_v_r   <= nxt_v_s;
            resv_r     <= resv_nxt_s;
            for (int k = 0; k < 3; k++) begin
                slot_rd_r[k] <= nxt_rd_s[k];
                slot_l_r[k]  <= nxt_l_s[k];
            end
            wb_valid_r <= wb_valid_nxt_s;
            wb_rd_r    <= wb_rd_nxt_s;
            wb_sel_r   <= wb_sel_nxt_s;
            en_m_r     <= en_m_nxt_s;
            en_w_r     <= en_w_nxt_s;
            busy_r     <= busy_nxt_s;
        end
    end

    assign req_ready = ready_s;
    assign en_e      = issue_s;
    assign en_m      = en_m_r;
    assign en_w      = en_w_r;
    assign wb_valid  = wb_valid_r;
    assign wb_rd     = wb_rd_r;
    assign wb_sel    = wb_sel_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mult_ctrl.sv
// Directed bench for mult_ctrl: hand-computed expectations for issue latency,
// stage enables, port collisions, hazards, x0, flush and reset.

module tb_mult_ctrl;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [1:0] req_lat;
    logic [4:0] req_rd;
    logic [4:0] req_rs1;
    logic [4:0] req_rs2;
    logic       flush;
    logic       en_e;
    logic       en_m;
    logic       en_w;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic [1:0] wb_sel;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    mult_ctrl #(.RD_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_lat   (req_lat),
        .req_rd    (req_rd),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .flush     (flush),
        .en_e      (en_e),
        .en_m      (en_m),
        .en_w      (en_w),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_sel    (wb_sel),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [1:0] lat,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        req_valid = v;
        req_op    = op;
        req_lat   = lat;
        req_rd    = rd;
        req_rs1   = rs1;
        req_rs2   = rs2;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 2'd0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic chk_wb(input string tag, input logic v, input logic [4:0] rd, input logic [1:0] sel);
        chk({tag, "_wbv"}, 32'(wb_valid), 32'(v));
        chk({tag, "_wbrd"}, 32'(wb_rd), 32'(rd));
        chk({tag, "_wbsel"}, 32'(wb_sel), 32'(sel));
    endtask

    initial begin
        rst_n = 1'b1;
        flush = 1'b0;
        req_valid = 1'b0; req_op = 2'b00; req_lat = 2'd0;
        req_rd = 5'd0; req_rs1 = 5'd0; req_rs2 = 5'd0;
        #1 rst_n = 1'b0;
        tick();
        tick();
        // Reset state
        chk_wb("rst", 1'b0, 5'd0, 2'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_enm", 32'(en_m), 32'd0);
        chk("rst_enw", 32'(en_w), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_ready", 32'(req_ready), 32'd1);

        // MUL L=1 rd=5
        drive(1'b1, 2'b00, 2'd1, 5'd5, 5'd0, 5'd0);
        chk("a_ready", 32'(req_ready), 32'd1);
        chk("a_ene", 32'(en_e), 32'd1);
        tick(); idle();
        chk_wb("a_t1", 1'b1, 5'd5, 2'd0);
        chk("a_enm", 32'(en_m), 32'd0);
        chk("a_enw", 32'(en_w), 32'd0);
        chk("a_busy1", 32'(busy), 32'd1);
        tick();
        chk_wb("a_t2", 1'b0, 5'd0, 2'd0);
        chk("a_busy2", 32'(busy), 32'd0);

        // MULHU rd=7 with req_lat=1 still takes three cycles
        drive(1'b1, 2'b11, 2'd1, 5'd7, 5'd0, 5'd0);
        chk("b_ene", 32'(en_e), 32'd1);
        tick(); idle();
        chk("b_enm1", 32'(en_m), 32'd1);
        chk("b_enw1", 32'(en_w), 32'd0);
        chk("b_wbv1", 32'(wb_valid), 32'd0);
        tick();
        chk("b_enm2", 32'(en_m), 32'd0);
        chk("b_enw2", 32'(en_w), 32'd1);
        chk("b_wbv2", 32'(wb_valid), 32'd0);
        tick();
        chk_wb("b_t3", 1'b1, 5'd7, 2'd2);
        chk("b_enw3", 32'(en_w), 32'd0);
        tick();
        chk("b_busy4", 32'(busy), 32'd0);

        // Port collision: L=3 rd=3 at T, L=1 rd=4 requested at T+2
        drive(1'b1, 2'b00, 2'd3, 5'd3, 5'd0, 5'd0);
        tick(); idle();
        tick();
        drive(1'b1, 2'b00, 2'd1, 5'd4, 5'd0, 5'd0);
        chk("c_ready2", 32'(req_ready), 32'd0);
        chk("c_ene2", 32'(en_e), 32'd0);
        tick();
        chk_wb("c_t3", 1'b1, 5'd3, 2'd2);
        chk("c_ready3", 32'(req_ready), 32'd1);
        chk("c_ene3", 32'(en_e), 32'd1);
        tick(); idle();
        chk_wb("c_t4", 1'b1, 5'd4, 2'd0);
        tick();
        chk_wb("c_t5", 1'b0, 5'd0, 2'd0);

        // RAW: L=2 rd=9, next op reads rs1=9
        drive(1'b1, 2'b00, 2'd2, 5'd9, 5'd0, 5'd0);
        tick();
        drive(1'b1, 2'b00, 2'd2, 5'd1, 5'd9, 5'd0);
        chk("d_ready1", 32'(req_ready), 32'd0);
        tick();
        chk("d_ready2", 32'(req_ready), 32'd1);
        chk_wb("d_t2", 1'b1, 5'd9, 2'd1);
        tick(); idle();
        chk("d_wbv3", 32'(wb_valid), 32'd0);
        tick();
        chk_wb("d_t4", 1'b1, 5'd1, 2'd1);
        tick();

        // x0 never stalls and still writes back
        drive(1'b1, 2'b00, 2'd3, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b1, 2'b00, 2'd3, 5'd0, 5'd0, 5'd0);
        chk("e_ready_x0", 32'(req_ready), 32'd1);
        tick(); idle();
        tick();
        chk_wb("e_t3", 1'b1, 5'd0, 2'd2);
        tick();
        chk_wb("e_t4", 1'b1, 5'd0, 2'd2);
        tick();
        chk("e_busy5", 32'(busy), 32'd0);

        // RAW through rs2 and WAW against a non-retiring slot
        drive(1'b1, 2'b00, 2'd3, 5'd6, 5'd0, 5'd0);
        tick();
        drive(1'b1, 2'b00, 2'd3, 5'd2, 5'd0, 5'd6);
        chk("f_ready_rs2", 32'(req_ready), 32'd0);
        drive(1'b1, 2'b00, 2'd3, 5'd6, 5'd0, 5'd0);
        chk("f_ready_waw", 32'(req_ready), 32'd0);
        idle();
        tick();
        tick();
        chk_wb("f_t3", 1'b1, 5'd6, 2'd2);
        tick();
        chk("f_busy4", 32'(busy), 32'd0);

        // Back-to-back L=1 issue every cycle
        drive(1'b1, 2'b00, 2'd1, 5'd1, 5'd0, 5'd0);
        tick();
        drive(1'b1, 2'b00, 2'd1, 5'd2, 5'd0, 5'd0);
        chk("g_ready2", 32'(req_ready), 32'd1);
        chk_wb("g_t1", 1'b1, 5'd1, 2'd0);
        tick();
        drive(1'b1, 2'b00, 2'd1, 5'd3, 5'd0, 5'd0);
        chk("g_ready3", 32'(req_ready), 32'd1);
        chk_wb("g_t2", 1'b1, 5'd2, 2'd0);
        tick(); idle();
        chk_wb("g_t3", 1'b1, 5'd3, 2'd0);
        tick();
        chk("g_wbv4", 32'(wb_valid), 32'd0);

        // req_lat=0 behaves as three cycles
        drive(1'b1, 2'b00, 2'd0, 5'd14, 5'd0, 5'd0);
        tick(); idle();
        tick();
        chk("h_wbv2", 32'(wb_valid), 32'd0);
        tick();
        chk_wb("h_t3", 1'b1, 5'd14, 2'd2);
        tick();

        // Flush with three L=3 ops in flight
        drive(1'b1, 2'b00, 2'd3, 5'd10, 5'd0, 5'd0);
        tick();
        drive(1'b1, 2'b00, 2'd3, 5'd11, 5'd0, 5'd0);
        chk("i_ready1", 32'(req_ready), 32'd1);
        tick();
        drive(1'b1, 2'b00, 2'd3, 5'd12, 5'd0, 5'd0);
        chk("i_ready2", 32'(req_ready), 32'd1);
        tick();
        flush = 1'b1;
        drive(1'b1, 2'b00, 2'd3, 5'd13, 5'd0, 5'd0);
        chk("i_ene_flush", 32'(en_e), 32'd0);
        chk_wb("i_t3", 1'b1, 5'd10, 2'd2);
        chk("i_busy3", 32'(busy), 32'd1);
        tick();
        flush = 1'b0;
        idle();
        chk_wb("i_t4", 1'b0, 5'd0, 2'd0);
        chk("i_busy4", 32'(busy), 32'd0);
        tick();
        chk("i_wbv5", 32'(wb_valid), 32'd0);
        tick();
        chk("i_wbv6", 32'(wb_valid), 32'd0);

        // Reset in the cycle after an L=3 issue
        drive(1'b1, 2'b00, 2'd3, 5'd8, 5'd0, 5'd0);
        tick(); idle();
        rst_n = 1'b0;
        #1;
        chk("j_busy_rst", 32'(busy), 32'd0);
        chk("j_wbv_rst", 32'(wb_valid), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("j_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("j_wbv_after", 32'(wb_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_ctrl.md
MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 Parameter: RD_W, 5, destination/source register index width.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: req_valid  in  1  decode presents a multiply op.
REQ-005 Port: req_ready  out  1  controller accepts op this cycle (combinational).
REQ-006 Port: req_op  in  2  MUL_OP: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-007 Port: req_lat  in  2  datapath-computed latency 1/2/3 (CYCLES of init stage); 0 shall be treated as 3.
REQ-008 Port: req_rd / req_rs1 / req_rs2  in  RD_W each  destination and source indices.
REQ-009 Port: flush  in  1  kill all in-flight multiplies.
REQ-010 Port: en_e, en_m, en_w  out  1 each  enables for init, mid and final stages.
REQ-011 Port: wb_valid  out  1  result present on writeback port this cycle.
REQ-012 Port: wb_rd  out  RD_W  destination of the writeback result.
REQ-013 Port: wb_sel  out  2  product select: 0 product1, 1 product2, 2 product3.
REQ-014 Port: busy  out  1  any op pending writeback.

Function
REQ-015 Issue occurs at a rising edge where req_valid & req_ready & !flush; issue cycle T.
REQ-016 en_e shall equal req_valid & req_ready & !flush (combinational).
REQ-017 An issued op shall write back in cycle T+L, where L is its effective latency: wb_valid=1, wb_rd=req_rd, wb_sel=L-1.
REQ-018 Upper-half ops (req_op != 00) shall always use L=3 regardless of req_lat.
REQ-019 Controller shall hold three slots S1..S3 (valid, rd, L); an op enters S1 at issue and shifts one slot per cycle; an op in slot Sk with L=k is in its writeback cycle and then retires.
REQ-020 en_m shall be 1 in the cycle a valid op in S1 has L>=2; en_w shall be 1 in the cycle a valid op in S2 has L=3.
REQ-021 Writeback reservation: a 3-bit vector, bit k-1 set means the port is claimed k cycles ahead; it shifts down by one each cycle.
REQ-022 req_ready shall be 0 if the post-shift reservation bit L-1 is already set (single writeback port, no two results in one cycle).
REQ-023 req_ready shall be 0 if req_rs1, req_rs2 or req_rd equals the rd of any valid slot not retiring this cycle, and that rd != 0 (RAW and WAW).
REQ-024 Index 0 shall never cause a hazard stall; x0 ops still produce wb_valid with wb_rd=0.
REQ-025 A slot retiring this cycle shall not block a new request.
REQ-026 Back-to-back issue of equal-latency ops shall be allowed every cycle when no hazard exists.
REQ-027 flush shall clear all slots and reservation bits at the edge; a wb in the flush cycle itself is still reported; no wb_valid afterwards for killed ops.
REQ-028 busy shall be 1 while any slot holds an op whose writeback cycle is not yet past.
REQ-029 wb_rd and wb_sel shall be 0 whenever wb_valid=0.

Reset
REQ-030 On rst_n low: all slots invalid, reservation 0; wb_valid, en_m, en_w, busy = 0; wb_rd, wb_sel = 0; req_ready=1 once rst_n high with empty slots.
REQ-031 Reset mid-operation shall discard all in-flight ops without any subsequent wb_valid.

Verification
REQ-032 MUL rd=5 L=1 issued at T -> wb_valid T+1, wb_rd=5, wb_sel=0; en_m, en_w stay 0.
REQ-033 MULHU rd=7, req_lat=1 at T -> en_m T+1, en_w T+2, wb_valid T+3, wb_sel=2.
REQ-034 L=3 rd=3 at T, then L=1 rd=4 requested T+2 -> req_ready=0 at T+2 (port collision), issued T+3, wb at T+4.
REQ-035 L=2 rd=9 at T, next op rs1=9 -> req_ready=0 at T+1, issued T+2; rs1=0 with pending rd=0 -> no stall.
REQ-036 Three L=3 ops issued T, T+1, T+2, flush at T+3 -> first op wb at T+3 reported, no wb at T+4/T+5, busy=0 at T+4.
REQ-037 rst_n low at T+1 after L=3 issue at T -> wb_valid never asserted; req_ready=1 after release.
